mem_port_arbiter: RTL

- Shares the single data RAM (combinational read, byte-enabled synchronous write) between two requesters.
  - Port m0: CPU load/store unit.
  - Port m1: debug/loader master (memory preload, post-ebreak dump).
- Per-cycle request/grant handshake with registered read-data return.
- Arbitration mode: round-robin or fixed priority with a starvation guard.
- halt input freezes all RAM traffic.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets two requesters share one data RAM. The RAM has a combinational read
// and a byte-enabled synchronous write.
//   m0 : CPU load/store unit
//   m1 : debug/loader master (memory preload, post-ebreak dump)
//
// Each port uses a per-cycle req/gnt handshake. A granted request goes to the
// RAM in the same cycle. Read data comes back registered, one cycle after the
// grant, together with a one-cycle rvalid pulse.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   halt             blocks all grants and RAM writes while high
//   mX_req/we/addr/wdata/be    requester X command (held until mX_gnt)
//   mX_gnt           requester X accepted this cycle
//   mX_rdata/rvalid  registered read return for requester X
//   ram_a/we/be/wd   RAM command
//   ram_rd           RAM combinational read data
//   busy             a grant is issued or a read return is presented
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_gnt,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_gnt,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  output logic [ADDR_W-1:0]   ram_a,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [DATA_W-1:0]   ram_wd,
  input  logic [DATA_W-1:0]   ram_rd,
  output logic                busy
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic              gnt0_s;
  logic              gnt1_s;
  logic              last_grant_r;   // 0 = m0 was granted last, 1 = m1
  logic [3:0]        wait_cnt_r;     // consecutive denied cycles of m1
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              rvalid0_r;
  logic              rvalid1_r;

  // Arbitration: decides which port, if any, is granted this cycle.
  // Reset does not gate this decision. Any state change is blocked at the
  // edge instead, so the grant stays a pure function of req, halt and state.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (halt) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (m0_req && m1_req) begin
      if (FIXED_PRIO != 0) begin
        // Starvation guard: after MAX_WAIT denials, m1 is forced through.
        if (wait_cnt_r == MAX_WAIT_C) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else begin
        if (last_grant_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end
    end else if (m0_req) begin
      gnt0_s = 1'b1;
    end else if (m1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // RAM command mux: the granted port drives the RAM.
  // When there is no grant, the last granted address is held.
  always_comb begin
    ram_a  = addr_hold_r;
    ram_we = 1'b0;
    ram_be = {BE_W{1'b0}};
    ram_wd = {DATA_W{1'b0}};
    if (gnt0_s) begin
      ram_a  = m0_addr;
      ram_we = m0_we;
      ram_be = m0_be;
      ram_wd = m0_wdata;
    end else if (gnt1_s) begin
      ram_a  = m1_addr;
      ram_we = m1_we;
      ram_be = m1_be;
      ram_wd = m1_wdata;
    end else begin
      ram_a  = addr_hold_r;
      ram_we = 1'b0;
    end
  end

  // Arbiter state, address hold and registered read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      wait_cnt_r   <= 4'd0;
      addr_hold_r  <= {ADDR_W{1'b0}};
      rdata0_r     <= {DATA_W{1'b0}};
      rdata1_r     <= {DATA_W{1'b0}};
      rvalid0_r    <= 1'b0;
      rvalid1_r    <= 1'b0;
    end else begin
      rvalid0_r <= gnt0_s & ~m0_we;
      rvalid1_r <= gnt1_s & ~m1_we;

      if (gnt0_s) begin
        last_grant_r <= 1'b0;
        addr_hold_r  <= m0_addr;
        if (!m0_we) begin
          rdata0_r <= ram_rd;
        end
      end else if (gnt1_s) begin
        last_grant_r <= 1'b1;
        addr_hold_r  <= m1_addr;
        if (!m1_we) begin
          rdata1_r <= ram_rd;
        end
      end

      // The counter freezes during halt, so the denial history survives a halt.
      if ((FIXED_PRIO != 0) && !halt) begin
        if (!m1_req || gnt1_s) begin
          wait_cnt_r <= 4'd0;
        end else if (wait_cnt_r < MAX_WAIT_C) begin
          wait_cnt_r <= wait_cnt_r + 4'd1;
        end
      end else if (FIXED_PRIO == 0) begin
        wait_cnt_r <= 4'd0;
      end
    end
  end

  assign m0_gnt    = gnt0_s;
  assign m1_gnt    = gnt1_s;
  assign m0_rdata  = rdata0_r;
  assign m1_rdata  = rdata1_r;
  assign m0_rvalid = rvalid0_r;
  assign m1_rvalid = rvalid1_r;
  assign busy      = gnt0_s | gnt1_s | rvalid0_r | rvalid1_r;

endmodule
